// File: rtl/am_if_tx_pkg.sv
// Shared constants, types and quarter-wave sine table for the AM IF test transmitter.
package am_if_tx_pkg;

    localparam int unsigned PHASE_W  = 24;
    localparam int unsigned LUT_AW   = 6;
    localparam int unsigned SAMPLE_W = 8;
    localparam int unsigned DEPTH_W  = 4;
    localparam int unsigned ENV_W    = 9;
    localparam int unsigned PROD_W   = 18;
    localparam int unsigned PIPE_LAT = 4;

    // Standard system clock and the matching 455 kHz carrier word (fcw = 455e3 * 2^24 / 16e6)
    localparam int unsigned F_CLK_HZ = 16_000_000;
    localparam logic [PHASE_W-1:0] CARRIER_FCW_455K = PHASE_W'(477102);

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Top LUT_AW+2 phase bits of both channels, all the sine lookup needs
    typedef struct packed {
        logic [LUT_AW+1:0] car;
        logic [LUT_AW+1:0] tone;
    } phase_msb_pair_t;

    // round(127*sin(pi/2*(i+0.5)/64)), i = 0..63
    function automatic logic [SAMPLE_W-2:0] sine_rom(input logic [LUT_AW-1:0] idx);
        sine_rom = 7'd0;
        case (idx)
            6'd0:  sine_rom = 7'd2;   6'd1:  sine_rom = 7'd5;   6'd2:  sine_rom = 7'd8;   6'd3:  sine_rom = 7'd11;
            6'd4:  sine_rom = 7'd14;  6'd5:  sine_rom = 7'd17;  6'd6:  sine_rom = 7'd20;  6'd7:  sine_rom = 7'd23;
            6'd8:  sine_rom = 7'd26;  6'd9:  sine_rom = 7'd29;  6'd10: sine_rom = 7'd32;  6'd11: sine_rom = 7'd35;
            6'd12: sine_rom = 7'd38;  6'd13: sine_rom = 7'd41;  6'd14: sine_rom = 7'd44;  6'd15: sine_rom = 7'd47;
            6'd16: sine_rom = 7'd50;  6'd17: sine_rom = 7'd53;  6'd18: sine_rom = 7'd56;  6'd19: sine_rom = 7'd58;
            6'd20: sine_rom = 7'd61;  6'd21: sine_rom = 7'd64;  6'd22: sine_rom = 7'd67;  6'd23: sine_rom = 7'd69;
            6'd24: sine_rom = 7'd72;  6'd25: sine_rom = 7'd74;  6'd26: sine_rom = 7'd77;  6'd27: sine_rom = 7'd79;
            6'd28: sine_rom = 7'd82;  6'd29: sine_rom = 7'd84;  6'd30: sine_rom = 7'd86;  6'd31: sine_rom = 7'd89;
            6'd32: sine_rom = 7'd91;  6'd33: sine_rom = 7'd93;  6'd34: sine_rom = 7'd95;  6'd35: sine_rom = 7'd97;
            6'd36: sine_rom = 7'd99;  6'd37: sine_rom = 7'd101; 6'd38: sine_rom = 7'd103; 6'd39: sine_rom = 7'd105;
            6'd40: sine_rom = 7'd106; 6'd41: sine_rom = 7'd108; 6'd42: sine_rom = 7'd110; 6'd43: sine_rom = 7'd111;
            6'd44: sine_rom = 7'd113; 6'd45: sine_rom = 7'd114; 6'd46: sine_rom = 7'd115; 6'd47: sine_rom = 7'd117;
            6'd48: sine_rom = 7'd118; 6'd49: sine_rom = 7'd119; 6'd50: sine_rom = 7'd120; 6'd51: sine_rom = 7'd121;
            6'd52: sine_rom = 7'd122; 6'd53: sine_rom = 7'd123; 6'd54: sine_rom = 7'd124; 6'd55: sine_rom = 7'd124;
            6'd56: sine_rom = 7'd125; 6'd57: sine_rom = 7'd125; 6'd58: sine_rom = 7'd126; 6'd59: sine_rom = 7'd126;
            6'd60: sine_rom = 7'd127; 6'd61: sine_rom = 7'd127; 6'd62: sine_rom = 7'd127; 6'd63: sine_rom = 7'd127;
            default: sine_rom = 7'd127;
        endcase
    endfunction

endpackage

// File: rtl/am_if_tx_if.sv
// Control and sample bus of the AM IF test transmitter.
interface am_if_tx_if;
    import am_if_tx_pkg::*;

    logic                 enable;
    logic [PHASE_W-1:0]   carrier_fcw;
    logic [PHASE_W-1:0]   tone_fcw;
    logic [DEPTH_W-1:0]   mod_depth;
    sample_t              if_tx_out;
    logic                 if_tx_valid;

    modport master (
        output enable,
        output carrier_fcw,
        output tone_fcw,
        output mod_depth,
        input  if_tx_out,
        input  if_tx_valid
    );

    modport slave (
        input  enable,
        input  carrier_fcw,
        input  tone_fcw,
        input  mod_depth,
        output if_tx_out,
        output if_tx_valid
    );

endinterface

// File: rtl/sine_quarter_lut.sv
// Registered full-wave sine from the top phase bits using quarter-wave folding of the shared ROM.
module sine_quarter_lut
    import am_if_tx_pkg::*;
(
    input  logic              clk,
    input  logic              RST,
    input  logic              en,
    input  logic [LUT_AW+1:0] phase_msb,
    output sample_t           sine_out
);

    logic [1:0]          quad_c;
    logic [LUT_AW-1:0]   idx_c;
    logic [SAMPLE_W-2:0] mag_c;
    sample_t             val_c;

    // Odd quadrants read the table mirrored, the lower half-wave is negated
    always_comb begin
        quad_c = phase_msb[LUT_AW+1:LUT_AW];
        idx_c  = phase_msb[LUT_AW-1:0];
        if (quad_c[0]) begin
            idx_c = ~idx_c;
        end
        mag_c = sine_rom(idx_c);
        val_c = quad_c[1] ? -sample_t'({1'b0, mag_c}) : sample_t'({1'b0, mag_c});
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            sine_out <= '0;
        end else if (en) begin
            sine_out <= val_c;
        end
    end

endmodule

// File: rtl/am_if_tx.sv
// AM IF test transmitter: carrier sine amplitude-modulated by a tone, 4-stage pipeline.
// Define AM_TX_DITHER_EN to add LFSR stochastic rounding ahead of the output shift.
module am_if_tx
    import am_if_tx_pkg::*;
(
    input  logic      clk,
    input  logic      RST,
    am_if_tx_if.slave bus
);

    logic [PHASE_W-1:0]  car_acc;
    logic [PHASE_W-1:0]  tone_acc;
    phase_msb_pair_t     ph_s1;
    logic [PIPE_LAT-1:0] vld_sr;

    sample_t             s_car_s2;
    sample_t             s_tone_s2;

    sample_t             car_s3;
    logic [ENV_W-1:0]    env_s3;

    sample_t             out_q;

    logic signed [12:0]       tm_c;
    logic signed [12:0]       tm_sh_c;
    logic [ENV_W-1:0]         env_c;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [PROD_W-1:0] sum_c;
    logic signed [PROD_W-1:0] q_c;
    sample_t                  sat_c;

    // S1: capture current phases, then advance; valid shift tracks every stage
    always_ff @(posedge clk) begin
        if (RST) begin
            car_acc  <= '0;
            tone_acc <= '0;
            ph_s1    <= '0;
            vld_sr   <= '0;
        end else begin
            vld_sr <= {vld_sr[PIPE_LAT-2:0], bus.enable};
            if (bus.enable) begin
                ph_s1.car  <= car_acc[PHASE_W-1 -: LUT_AW+2];
                ph_s1.tone <= tone_acc[PHASE_W-1 -: LUT_AW+2];
                car_acc    <= car_acc + bus.carrier_fcw;
                tone_acc   <= tone_acc + bus.tone_fcw;
            end
        end
    end

    // S2: both sine lookups
    sine_quarter_lut u_car_lut (
        .clk       (clk),
        .RST       (RST),
        .en        (vld_sr[0]),
        .phase_msb (ph_s1.car),
        .sine_out  (s_car_s2)
    );

    sine_quarter_lut u_tone_lut (
        .clk       (clk),
        .RST       (RST),
        .en        (vld_sr[0]),
        .phase_msb (ph_s1.tone),
        .sine_out  (s_tone_s2)
    );

`ifdef AM_TX_DITHER_EN
    logic [15:0] lfsr_q;

    // Fibonacci taps 16,14,13,11, stepped once per output sample
    always_ff @(posedge clk) begin
        if (RST) begin
            lfsr_q <= 16'hACE1;
        end else if (vld_sr[2]) begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end
`endif

    // Envelope, product, rounding and saturation guard
    always_comb begin
        tm_c    = 13'(s_tone_s2) * 13'($signed({1'b0, bus.mod_depth}));
        tm_sh_c = tm_c >>> 4;
        env_c   = ENV_W'(tm_sh_c + 13'sd128);
        prod_c  = PROD_W'(car_s3) * PROD_W'($signed({1'b0, env_s3}));
`ifdef AM_TX_DITHER_EN
        sum_c   = prod_c + PROD_W'($signed({1'b0, lfsr_q[7:0]}));
`else
        sum_c   = prod_c;
`endif
        q_c     = sum_c >>> 8;
        sat_c   = q_c[SAMPLE_W-1:0];
        if (q_c > 18'sd127) begin
            sat_c = 8'sd127;
        end else if (q_c < -18'sd127) begin
            sat_c = -8'sd127;
        end
    end

    // S3 and S4 registers, each gated by its own stage valid
    always_ff @(posedge clk) begin
        if (RST) begin
            car_s3 <= '0;
            env_s3 <= '0;
            out_q  <= '0;
        end else begin
            if (vld_sr[1]) begin
                car_s3 <= s_car_s2;
                env_s3 <= env_c;
            end
            if (vld_sr[2]) begin
                out_q <= sat_c;
            end
        end
    end

    assign bus.if_tx_out   = out_q;
    assign bus.if_tx_valid = vld_sr[PIPE_LAT-1];

endmodule

// File: tb/tb_am_if_tx.sv
// Directed self-checking bench for am_if_tx with hand-computed sample values.
module tb_am_if_tx;
    import am_if_tx_pkg::*;

    logic clk = 1'b0;
    logic RST;
    int   n_cmp = 0;
    int   n_mis = 0;

    int seq4  [4] = '{1, 63, -1, -64};
    int gap_v [9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
    int gap_o [9] = '{63, -1, -64, -64, -64, -64, 1, 63, -1};

    am_if_tx_if bus ();

    am_if_tx u_dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_pair(input string tag, input int exp_vld, input int exp_out);
        check({tag, ".valid"}, {31'b0, bus.if_tx_valid}, exp_vld);
        check({tag, ".out"}, 32'(bus.if_tx_out), exp_out);
    endtask

    // One-clock reset, then four samples from phase 0 after the pipeline latency
    task automatic reset_and_run(input string tag, input logic [PHASE_W-1:0] car, input logic [PHASE_W-1:0] tone,
                                 input logic [DEPTH_W-1:0] depth, input int e0, input int e1, input int e2, input int e3);
        RST             = 1'b1;
        bus.enable      = 1'b1;
        bus.carrier_fcw = car;
        bus.tone_fcw    = tone;
        bus.mod_depth   = depth;
        step();
        check_pair({tag, ".rst"}, 0, 0);
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_pair($sformatf("%s.lat%0d", tag, i), 0, 0);
        end
        step(); check_pair({tag, ".s0"}, 1, e0);
        step(); check_pair({tag, ".s1"}, 1, e1);
        step(); check_pair({tag, ".s2"}, 1, e2);
        step(); check_pair({tag, ".s3"}, 1, e3);
    endtask

    initial begin
        RST             = 1'b1;
        bus.enable      = 1'b1;
        bus.carrier_fcw = 24'h400000;
        bus.tone_fcw    = '0;
        bus.mod_depth   = '0;

        // Two reset clocks with enable held high
        step(); check_pair("rst0", 0, 0);
        step(); check_pair("rst1", 0, 0);
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_pair($sformatf("lat%0d", i), 0, 0);
        end

        // f_clk/4 carrier, unmodulated
        for (int i = 0; i < 5; i++) begin
            step();
            check_pair($sformatf("quarter%0d", i), 1, seq4[i % 4]);
        end

        // Three-clock enable gap: bubbles appear after the latency, sequence resumes
        bus.enable = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step();
            check_pair($sformatf("gap%0d", i), gap_v[i], gap_o[i]);
            if (i == 2) bus.enable = 1'b1;
        end

        // Mid-stream single-clock reset restarts at phase 0
        reset_and_run("midrst", 24'h400000, 24'h000000, 4'd0, 1, 63, -1, -64);

        // Carrier word wraps through 2^24-1
        reset_and_run("wrap", 24'hFFFFFF, 24'h000000, 4'd0, 1, -1, -1, -1);

        // Full depth, tone in phase with carrier: peak 122, trough env 8 on negative carrier
        reset_and_run("envpk", 24'h400000, 24'h400000, 4'd15, 1, 122, -1, -4);

        // Full depth, tone in antiphase: carrier 127 with env 8 gives 3
        reset_and_run("envtr", 24'h400000, 24'hC00000, 4'd15, 1, 3, -1, -123);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
